dcache_ctrl: RTL and testbench

//  Direct-mapped, write-back data cache between the CPU load/store path and the

---
 rtl/dcache_ctrl.sv | 154 +++++++++++++++
 tb/tb_dcache_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_ctrl
//  Description : Direct-mapped, write-back data cache between the CPU
//                load/store path and a block-wide data memory. Hits complete
//                with no stall. Misses stall the CPU while the cache runs the
//                memory read handshake itself, writing back a dirty victim
//                line first when one is present.
//  Revision    : 1.0  initial release
// ============================================================================
module dcache_ctrl #(
    parameter int BLOCKS    = 8,
    parameter int BLK_BYTES = 4,
    parameter int ADDR_W    = 8
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_read,
    input  logic                                 i_write,
    input  logic [ADDR_W-1:0]                    i_address,
    input  logic [7:0]                           i_writedata,
    output logic [7:0]                           o_readdata,
    output logic                                 o_busywait,
    output logic                                 o_mem_read,
    output logic                                 o_mem_write,
    output logic [ADDR_W-$clog2(BLK_BYTES)-1:0]  o_mem_address,
    output logic [8*BLK_BYTES-1:0]               o_mem_writedata,
    input  logic [8*BLK_BYTES-1:0]               i_mem_readdata,
    input  logic                                 i_mem_busywait
);

    localparam int c_IDX_W  = $clog2(BLOCKS);
    localparam int c_OFF_W  = $clog2(BLK_BYTES);
    localparam int c_TAG_W  = ADDR_W - c_IDX_W - c_OFF_W;
    localparam int c_WORD_W = 8 * BLK_BYTES;
    localparam int c_MADR_W = c_TAG_W + c_IDX_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WBACK  = 2'd1,
        S_MEMRD  = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    state_t                r_state;
    logic [BLOCKS-1:0]     r_valid;
    logic [BLOCKS-1:0]     r_dirty;
    logic [c_TAG_W-1:0]    r_tag  [BLOCKS];
    logic [c_WORD_W-1:0]   r_data [BLOCKS];
    logic [c_WORD_W-1:0]   r_fill;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic [c_MADR_W-1:0]   r_mem_address;
    logic [c_WORD_W-1:0]   r_mem_writedata;

    logic [c_TAG_W-1:0]    w_tag;
    logic [c_IDX_W-1:0]    w_idx;
    logic [c_OFF_W-1:0]    w_off;
    logic                  w_req;
    logic                  w_hit;
    logic                  w_idle_hit;
    logic                  w_store;
    logic [c_WORD_W-1:0]   w_line;
    logic [7:0]            w_byte;

    assign w_tag      = i_address[ADDR_W-1 -: c_TAG_W];
    assign w_idx      = i_address[c_OFF_W +: c_IDX_W];
    assign w_off      = i_address[c_OFF_W-1:0];
    assign w_req      = i_read | i_write;
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_idle_hit = (r_state == S_IDLE) && w_hit;
    // A simultaneous read and write is serviced as a store only.
    assign w_store    = i_write && w_idle_hit;
    assign w_line     = r_data[w_idx];
    assign w_byte     = w_line[{w_off, 3'b000} +: 8];

    assign o_busywait      = w_req && !w_idle_hit;
    assign o_readdata      = (i_read && !i_write && w_idle_hit) ? w_byte : 8'd0;
    assign o_mem_read      = r_mem_read;
    assign o_mem_write     = r_mem_write;
    assign o_mem_address   = r_mem_address;
    assign o_mem_writedata = r_mem_writedata;

    // Miss-handling FSM with registered memory strobes, plus valid/dirty tracking.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= S_IDLE;
            r_valid         <= '0;
            r_dirty         <= '0;
            r_fill          <= '0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_address   <= '0;
            r_mem_writedata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_store) begin
                        r_dirty[w_idx] <= 1'b1;
                    end
                    if (w_req && !w_hit) begin
                        if (r_valid[w_idx] && r_dirty[w_idx]) begin
                            r_state         <= S_WBACK;
                            r_mem_write     <= 1'b1;
                            r_mem_address   <= {r_tag[w_idx], w_idx};
                            r_mem_writedata <= w_line;
                        end else begin
                            r_state       <= S_MEMRD;
                            r_mem_read    <= 1'b1;
                            r_mem_address <= {w_tag, w_idx};
                        end
                    end
                end
                S_WBACK: begin
                    if (!i_mem_busywait) begin
                        r_state         <= S_MEMRD;
                        r_mem_write     <= 1'b0;
                        r_mem_read      <= 1'b1;
                        r_mem_address   <= {w_tag, w_idx};
                        r_mem_writedata <= '0;
                    end
                end
                S_MEMRD: begin
                    if (!i_mem_busywait) begin
                        r_state       <= S_UPDATE;
                        r_mem_read    <= 1'b0;
                        r_mem_address <= '0;
                        r_fill        <= i_mem_readdata;
                    end
                end
                S_UPDATE: begin
                    r_state        <= S_IDLE;
                    r_valid[w_idx] <= 1'b1;
                    r_dirty[w_idx] <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Tag and data arrays: line fill on UPDATE, byte merge on a store hit.
    always_ff @(posedge i_clk) begin
        if (r_state == S_UPDATE) begin
            r_data[w_idx] <= r_fill;
            r_tag[w_idx]  <= w_tag;
        end else if (w_store) begin
            r_data[w_idx][{w_off, 3'b000} +: 8] <= i_writedata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_ctrl
//  Description : Directed self-checking bench for dcache_ctrl with a small
//                block memory model that stalls a fixed number of cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dcache_ctrl;

    localparam int c_TM = 5;

    logic        clk;
    logic        rst_n;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    int n_vec  = 0;
    int n_fail = 0;

    logic [31:0] mem [64];
    logic [1:0]  prev_kind;
    int          cnt;

    dcache_ctrl #(.BLOCKS(8), .BLK_BYTES(4), .ADDR_W(8)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_read          (read),
        .i_write         (write),
        .i_address       (address),
        .i_writedata     (writedata),
        .o_readdata      (readdata),
        .o_busywait      (busywait),
        .o_mem_read      (mem_read),
        .o_mem_write     (mem_write),
        .o_mem_address   (mem_address),
        .o_mem_writedata (mem_writedata),
        .i_mem_readdata  (mem_readdata),
        .i_mem_busywait  (mem_busywait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: busy for c_TM cycles after a new strobe, then ready for one.
    always @(negedge clk) begin
        if (!mem_read && !mem_write) begin
            mem_busywait = 1'b0;
            cnt = 0;
        end else if ({mem_read, mem_write} != prev_kind) begin
            mem_busywait = 1'b1;
            cnt = 1;
        end else if (cnt < c_TM) begin
            mem_busywait = 1'b1;
            cnt = cnt + 1;
        end else begin
            mem_busywait = 1'b0;
            if (mem_write) mem[mem_address] = mem_writedata;
        end
        prev_kind = {mem_read, mem_write};
        mem_readdata = mem[mem_address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step one clock and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_not_busy(input string tag);
        int k;
        k = 0;
        while (busywait && k < 60) begin
            step();
            k++;
        end
        chk({tag, "_timeout"}, {31'd0, busywait}, 32'd0);
    endtask

    task automatic wait_mem_read(input string tag);
        int k;
        k = 0;
        while (!mem_read && k < 60) begin
            step();
            k++;
        end
        chk({tag, "_timeout"}, {31'd0, mem_read}, 32'd1);
    endtask

    task automatic req(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        read = r; write = w; address = a; writedata = d;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[6'h05] = 32'hDDCCBBAA;
        mem[6'h2D] = 32'h44332211;
        prev_kind = 2'b00;
        cnt = 0;
        mem_busywait = 1'b0;
        mem_readdata = 32'd0;
        rst_n = 1'b0;
        read = 1'b0; write = 1'b0; address = 8'd0; writedata = 8'd0;
        step(); step();
        rst_n = 1'b1;
        step(); step();

        // 1: mid-cycle reset pulse with no request
        #2 rst_n = 1'b0;
        #1;
        chk("rst_outputs", {readdata, busywait, mem_read, mem_write, mem_address},
            32'd0);
        chk("rst_mem_wdata", mem_writedata, 32'd0);
        #1 rst_n = 1'b1;
        step();

        // 2: clean miss on empty cache
        req(1'b1, 1'b0, 8'h15, 8'h00);
        chk("miss_busy", {31'd0, busywait}, 32'd1);
        step();
        chk("miss_mem_read", {31'd0, mem_read}, 32'd1);
        chk("miss_mem_write", {31'd0, mem_write}, 32'd0);
        chk("miss_mem_addr", {26'd0, mem_address}, 32'h05);
        wait_not_busy("fill1");
        chk("fill1_readdata", {24'd0, readdata}, 32'hBB);
        chk("fill1_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        step();

        // 3: store hit then load hit
        req(1'b0, 1'b1, 8'h16, 8'h5A);
        chk("st_hit_busy", {31'd0, busywait}, 32'd0);
        chk("st_hit_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        step();
        req(1'b1, 1'b0, 8'h16, 8'h00);
        chk("ld_hit_busy", {31'd0, busywait}, 32'd0);
        chk("ld_hit_data", {24'd0, readdata}, 32'h5A);
        step();

        // 4: dirty conflict miss -> write-back then fill
        req(1'b1, 1'b0, 8'hB5, 8'h00);
        chk("wb_busy", {31'd0, busywait}, 32'd1);
        step();
        chk("wb_strobes", {30'd0, mem_read, mem_write}, 32'b01);
        chk("wb_addr", {26'd0, mem_address}, 32'h05);
        chk("wb_data", mem_writedata, 32'hDD5ABBAA);
        wait_mem_read("wb_to_rd");
        chk("rd_after_wb_write", {31'd0, mem_write}, 32'd0);
        chk("rd_after_wb_addr", {26'd0, mem_address}, 32'h2D);
        wait_not_busy("fill2");
        chk("fill2_readdata", {24'd0, readdata}, 32'h22);
        step();

        // 5: reset in the middle of a memory read
        req(1'b1, 1'b0, 8'h15, 8'h00);
        step();
        chk("pre_rst_mem_read", {31'd0, mem_read}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_read", {31'd0, mem_read}, 32'd0);
        chk("rst_mid_mem_addr", {26'd0, mem_address}, 32'd0);
        step();
        #2 rst_n = 1'b1;
        step();
        chk("post_rst_miss", {31'd0, mem_read}, 32'd1);
        wait_not_busy("fill3");
        chk("fill3_readdata", {24'd0, readdata}, 32'hBB);
        step();

        // 6: read and write together on a hit act as a store
        req(1'b1, 1'b1, 8'h14, 8'h77);
        chk("rw_busy", {31'd0, busywait}, 32'd0);
        chk("rw_readdata", {24'd0, readdata}, 32'd0);
        step();
        req(1'b1, 1'b0, 8'h14, 8'h00);
        chk("rw_readback", {24'd0, readdata}, 32'h77);
        step();

        // Evicting that line writes back the merged byte
        req(1'b1, 1'b0, 8'hB4, 8'h00);
        step();
        chk("wb2_strobes", {30'd0, mem_read, mem_write}, 32'b01);
        chk("wb2_data", mem_writedata, 32'hDD5ABB77);
        wait_not_busy("fill4");
        chk("fill4_readdata", {24'd0, readdata}, 32'h11);
        step();
        req(1'b0, 1'b0, 8'h00, 8'h00);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
